// File: rtl/byte_lane_arbiter_if.sv
// Requester/arbiter bundle for byte_lane_arbiter: per-requester write handshake,
// result-register clear and the shared result/commit status.
interface byte_lane_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LANE_W  = 8
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [2*NUM_REQ-1:0]        req_lane;
  logic [LANE_W*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        clear;
  logic [4*LANE_W-1:0]         result;
  logic                        wr_done;
  logic [1:0]                  wr_src;
  logic                        busy;

  modport master (
    output req_valid, req_lane, req_data, clear,
    input  req_ready, result, wr_done, wr_src, busy
  );

  modport slave (
    input  req_valid, req_lane, req_data, clear,
    output req_ready, result, wr_done, wr_src, busy
  );
endinterface

// File: rtl/byte_lane_arbiter.sv
// Four-requester arbiter writing single bytes into a shared 4-lane result register.
// Round-robin by default; define BYTE_LANE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module byte_lane_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LANE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  byte_lane_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned RES_W = 4 * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  logic [IDX_W-1:0]   cap_lane;
  logic [LANE_W-1:0]  cap_data;
  logic [RES_W-1:0]   result_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               wr_done_q;
  logic [IDX_W-1:0]   wr_src_q;
  logic               busy_q;

  logic [IDX_W-1:0]   ptr_base_c;
  logic [IDX_W-1:0]   idx_c;
  logic               win_found_c;
  logic [IDX_W-1:0]   win_idx_c;

  // Search base: a commit in this cycle already moves the pointer past the writer.
  assign ptr_base_c = (state == WRITE) ? IDX_W'(grant_idx + 2'd1) : ptr;

  // Winner select; descending scan so the highest-priority candidate is assigned last.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    idx_c       = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
`ifdef BYTE_LANE_ARB_FIXED_PRIO_EN
      idx_c = IDX_W'(i);
`else
      idx_c = ptr_base_c + IDX_W'(i);
`endif
      if (bus.req_valid[idx_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = idx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      xfer        <= 1'b0;
      cap_lane    <= '0;
      cap_data    <= '0;
      result_q    <= '0;
      req_ready_q <= '0;
      wr_done_q   <= 1'b0;
      wr_src_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      wr_done_q   <= 1'b0;
      if (bus.clear) begin
        result_q <= '0;
      end
      case (state)
        IDLE: begin
          if (win_found_c) begin
            state       <= GRANT;
            grant_idx   <= win_idx_c;
            req_ready_q <= NUM_REQ'(1) << win_idx_c;
            busy_q      <= 1'b1;
          end
        end
        GRANT: begin
          // Ready is held for the granted requester, so acceptance reduces to its valid.
          state     <= WRITE;
          xfer      <= bus.req_valid[grant_idx];
          cap_lane  <= bus.req_lane[{grant_idx, 1'b0} +: IDX_W];
          cap_data  <= bus.req_data[LANE_W*grant_idx +: LANE_W];
          wr_done_q <= bus.req_valid[grant_idx];
          wr_src_q  <= grant_idx;
        end
        WRITE: begin
          if (xfer && !bus.clear) begin
            result_q[LANE_W*cap_lane +: LANE_W] <= cap_data;
          end
          ptr <= IDX_W'(grant_idx + 2'd1);
          if (win_found_c) begin
            state       <= GRANT;
            grant_idx   <= win_idx_c;
            req_ready_q <= NUM_REQ'(1) << win_idx_c;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.result    = result_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.busy      = busy_q;

endmodule
